// File: rtl/mem_arbiter.sv
// Round-robin arbiter sequencing CPU and I/O accesses onto a single-port RAM; write ack 2 cycles, read ack 2+RD_LAT cycles after grant.
// Masters hold req until ack (no backpressure path into RAM); cpu_stall freezes the CPU until its own ack cycle.
module mem_arbiter #(
    parameter int ADDR_W = 15,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [31:0]       io_addr,
    input  logic [31:0]       io_wdata,
    output logic [31:0]       io_rdata,
    output logic              io_ack,
    output logic              bad_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wren,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_IO  = 1'b1;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic              oor_q, oor_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic              ram_wren_q, ram_wren_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic [31:0]       io_rdata_q, io_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              io_ack_q, io_ack_d;
    logic              bad_q, bad_d;

    logic              grant_io;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_oor;
    logic              unused_addr_bits;

    // On a tie the master that did not win last time is granted.
    assign grant_io  = io_req & (~cpu_req | (last_q == OWN_CPU));
    assign sel_we    = grant_io ? io_we    : cpu_we;
    assign sel_addr  = grant_io ? io_addr  : cpu_addr;
    assign sel_wdata = grant_io ? io_wdata : cpu_wdata;
    assign sel_oor   = |sel_addr[31:ADDR_W+2];
    assign unused_addr_bits = ^{cpu_addr[1:0], io_addr[1:0]};

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        oor_d       = oor_q;
        cnt_d       = cnt_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_wren_d  = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        io_rdata_d  = io_rdata_q;
        cpu_ack_d   = 1'b0;
        io_ack_d    = 1'b0;
        bad_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req | io_req) begin
                    owner_d     = grant_io;
                    last_d      = grant_io;
                    we_d        = sel_we;
                    oor_d       = sel_oor;
                    ram_addr_d  = sel_addr[ADDR_W+1:2];
                    ram_wdata_d = sel_wdata;
                    ram_wren_d  = sel_we & ~sel_oor;
                    cnt_d       = 2'd0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    cpu_ack_d = (owner_q == OWN_CPU);
                    io_ack_d  = (owner_q == OWN_IO);
                    bad_d     = oor_q;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'(RD_LAT - 1)) begin
                    if (owner_q == OWN_CPU) cpu_rdata_d = oor_q ? 32'd0 : ram_rdata;
                    else                    io_rdata_d  = oor_q ? 32'd0 : ram_rdata;
                    cpu_ack_d = (owner_q == OWN_CPU);
                    io_ack_d  = (owner_q == OWN_IO);
                    bad_d     = oor_q;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_DONE: begin
                // Requests are ignored here so the just-acked master is not served twice.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_CPU;
            last_q      <= OWN_IO;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            cnt_q       <= 2'd0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 32'd0;
            ram_wren_q  <= 1'b0;
            cpu_rdata_q <= 32'd0;
            io_rdata_q  <= 32'd0;
            cpu_ack_q   <= 1'b0;
            io_ack_q    <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            cnt_q       <= cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wren_q  <= ram_wren_d;
            cpu_rdata_q <= cpu_rdata_d;
            io_rdata_q  <= io_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            io_ack_q    <= io_ack_d;
            bad_q       <= bad_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign io_rdata  = io_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign io_ack    = io_ack_q;
    assign bad_addr  = bad_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_wren  = ram_wren_q;
    assign cpu_stall = cpu_req & ~((state_q == S_DONE) & (owner_q == OWN_CPU));

endmodule
